// File: rtl/fpu_cmd_sequencer_if.sv
// Handshake bundle between the FPU command sequencer and the floating-point
// datapath: operation code and operands out, completion strobe, result and
// exception flags back.
interface fpu_cmd_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       fpu_op;
  logic [WIDTH-1:0] fpu_a;
  logic [WIDTH-1:0] fpu_b;
  logic             fpu_start;
  logic             fpu_done;
  logic [WIDTH-1:0] fpu_result;
  logic [3:0]       fpu_flags;

  // Sequencer side: issues operations, receives completion.
  modport master (
    output fpu_op, fpu_a, fpu_b, fpu_start,
    input  fpu_done, fpu_result, fpu_flags
  );

  // Datapath side: consumes operations, reports completion.
  modport slave (
    input  fpu_op, fpu_a, fpu_b, fpu_start,
    output fpu_done, fpu_result, fpu_flags
  );
endinterface

// File: rtl/fpu_cmd_sequencer.sv
// SPI FPU command sequencer.
// Parses command frames from the SPI receive byte stream, assembles operands,
// issues one operation at a time to the FPU datapath (start/done handshake),
// captures result and sticky flags, and feeds result/status bytes to the SPI
// transmit path.
// Optional feature: define FPU_SEQ_TIMEOUT_EN to bound the WAIT state by
// TIMEOUT cycles; without it WAIT is unbounded and the tmo status bit is 0.
module fpu_cmd_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                rx_valid,
  input  logic [7:0]          rx_byte,
  input  logic                tx_load,
  output logic [7:0]          tx_byte,
  output logic                busy,
  fpu_cmd_sequencer_if.master fpu
);

  localparam int NB    = WIDTH / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int PTR_W = $clog2(NB + 1);

  localparam logic [3:0] CMD_NOP     = 4'h0;
  localparam logic [3:0] CMD_ADD     = 4'h1;
  localparam logic [3:0] CMD_DIV     = 4'h4;
  localparam logic [3:0] CMD_SQRT    = 4'h5;
  localparam logic [3:0] CMD_RD_RES  = 4'h8;
  localparam logic [3:0] CMD_RD_STAT = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ISSUE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t state, state_nxt, st_eff;

  // Command decode of the byte on the receive strobe
  logic [3:0] cmd_code;
  logic       is_bin, is_un, is_legal;
  logic       in_op, in_load, cmd_hit, cnt_last, load_done, done_hit;
  logic       tmo_hit;

  // Operand assembly and issue registers
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] asm_reg, asm_nxt;
  logic [2:0]         cmd_op;
  logic               cmd_bin;
  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               start;

  // Result, sticky status and transmit source
  logic [WIDTH-1:0] result, result_nxt;
  logic [3:0]       sticky_flags, flags_nxt;
  logic             sticky_ill, ill_nxt;
  logic             sticky_ovr, ovr_nxt;
  logic             tmo, tmo_nxt;
  logic             clr, clr_arm, clr_arm_nxt;
  logic             busy_nxt;
  logic [7:0]       status_nxt;
  logic             tx_res, tx_res_nxt;
  logic [PTR_W-1:0] tx_ptr, tx_ptr_nxt;
  logic [7:0]       tx_byte_nxt;

  // Byte p of the result, MSB first; zero once the pointer has run past it.
  function automatic logic [7:0] result_byte(input logic [WIDTH-1:0] r,
                                             input logic [PTR_W-1:0] p);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (p == PTR_W'(i)) b = r[(NB-1-i)*8 +: 8];
    end
    return b;
  endfunction

  assign cmd_code = rx_byte[7:4];
  assign is_bin   = (cmd_code >= CMD_ADD) && (cmd_code <= CMD_DIV);
  assign is_un    = (cmd_code == CMD_SQRT);
  assign is_legal = is_bin || is_un || (cmd_code == CMD_NOP) ||
                    (cmd_code == CMD_RD_RES) || (cmd_code == CMD_RD_STAT);

  // A running operation is immune to frame_start; elsewhere frame_start wins
  // and a byte arriving with it is parsed as a fresh command.
  assign in_op     = (state == S_ISSUE) || (state == S_WAIT);
  assign st_eff    = (frame_start && !in_op) ? S_IDLE : state;
  assign in_load   = (st_eff == S_LOAD_A) || (st_eff == S_LOAD_B);
  assign cmd_hit   = rx_valid && (st_eff == S_IDLE);
  assign cnt_last  = (cnt == CNT_W'(NB - 1));
  assign load_done = rx_valid && cnt_last &&
                     ((st_eff == S_LOAD_B) || ((st_eff == S_LOAD_A) && !cmd_bin));
  assign done_hit  = (state == S_WAIT) && fpu.fpu_done;

  // Binary operands shift through both halves (A ends up high, B low);
  // a unary operand only fills the low half.
  assign asm_nxt = (rx_valid && in_load) ? {asm_reg[2*WIDTH-9:0], rx_byte} : asm_reg;

  assign clr = clr_arm && tx_load;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] wait_cnt;

  // A done on the last allowed cycle still completes normally.
  assign tmo_hit = (state == S_WAIT) && !fpu.fpu_done &&
                   (wait_cnt == TMO_W'(TIMEOUT - 1));
  assign tmo_nxt = (tmo & ~clr) | tmo_hit;

  // Count cycles spent in WAIT; cleared whenever the sequencer is elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      tmo      <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      tmo      <= tmo_nxt;
    end
  end
`else
  logic unused_timeout;

  // The limit only matters when the WAIT counter is built.
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
  assign tmo            = 1'b0;
  assign tmo_nxt        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = st_eff;
    case (st_eff)
      S_IDLE: begin
        if (rx_valid) begin
          if (is_bin || is_un) state_nxt = S_LOAD_A;
          else if (!is_legal)  state_nxt = S_DROP;
        end
      end
      S_LOAD_A: begin
        if (rx_valid && cnt_last) state_nxt = cmd_bin ? S_LOAD_B : S_ISSUE;
      end
      S_LOAD_B: begin
        if (rx_valid && cnt_last) state_nxt = S_ISSUE;
      end
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (fpu.fpu_done || tmo_hit) state_nxt = S_IDLE;
      end
      S_DROP:   state_nxt = S_DROP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    start = (state == S_ISSUE);
    busy  = (state == S_ISSUE) || (state == S_WAIT);
  end

  assign fpu.fpu_start = start;
  assign fpu.fpu_op    = op_reg;
  assign fpu.fpu_a     = a_reg;
  assign fpu.fpu_b     = b_reg;

  // Next values of sticky status, result and transmit source; tx_byte is
  // built from these so it reflects a change on the very next cycle.
  always_comb begin
    result_nxt  = done_hit ? fpu.fpu_result : result;
    ill_nxt     = (sticky_ill & ~clr) | (cmd_hit && !is_legal);
    ovr_nxt     = (sticky_ovr & ~clr) | (rx_valid && in_op && (rx_byte != 8'h00));
    flags_nxt   = (sticky_flags & {4{~clr}}) | (done_hit ? fpu.fpu_flags : 4'b0000);
    busy_nxt    = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
    status_nxt  = {busy_nxt, ill_nxt, ovr_nxt, tmo_nxt, flags_nxt};

    clr_arm_nxt = clr_arm;
    if (cmd_hit && (cmd_code == CMD_RD_STAT)) clr_arm_nxt = 1'b1;
    else if (tx_load)                         clr_arm_nxt = 1'b0;

    tx_res_nxt = tx_res;
    tx_ptr_nxt = tx_ptr;
    if (frame_start) begin
      tx_res_nxt = 1'b0;
      tx_ptr_nxt = '0;
    end else if (tx_load && tx_res && (tx_ptr != PTR_W'(NB))) begin
      tx_ptr_nxt = tx_ptr + 1'b1;
    end
    if (cmd_hit && (cmd_code == CMD_RD_RES)) begin
      tx_res_nxt = 1'b1;
      tx_ptr_nxt = '0;
    end

    tx_byte_nxt = tx_res_nxt ? result_byte(result_nxt, tx_ptr_nxt) : status_nxt;
  end

  // Operand assembly, issue registers, result capture and transmit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      asm_reg      <= '0;
      cmd_op       <= 3'd0;
      cmd_bin      <= 1'b0;
      op_reg       <= 3'd0;
      a_reg        <= '0;
      b_reg        <= '0;
      result       <= '0;
      sticky_flags <= 4'b0000;
      sticky_ill   <= 1'b0;
      sticky_ovr   <= 1'b0;
      clr_arm      <= 1'b0;
      tx_res       <= 1'b0;
      tx_ptr       <= '0;
      tx_byte      <= 8'h00;
    end else begin
      asm_reg <= asm_nxt;

      if (in_load && rx_valid) cnt <= cnt_last ? '0 : cnt + 1'b1;
      else if (!in_load)       cnt <= '0;

      if (cmd_hit && (is_bin || is_un)) begin
        cmd_op  <= rx_byte[6:4];
        cmd_bin <= is_bin;
      end

      // Operands only move when a complete frame commits, so an aborted
      // frame never disturbs what the datapath last saw.
      if (load_done) begin
        op_reg <= cmd_op;
        if (cmd_bin) begin
          a_reg <= asm_nxt[2*WIDTH-1:WIDTH];
          b_reg <= asm_nxt[WIDTH-1:0];
        end else begin
          a_reg <= asm_nxt[WIDTH-1:0];
        end
      end

      result       <= result_nxt;
      sticky_flags <= flags_nxt;
      sticky_ill   <= ill_nxt;
      sticky_ovr   <= ovr_nxt;
      clr_arm      <= clr_arm_nxt;
      tx_res       <= tx_res_nxt;
      tx_ptr       <= tx_ptr_nxt;
      tx_byte      <= tx_byte_nxt;
    end
  end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Directed testbench for fpu_cmd_sequencer: command frames, operand issue,
// result/status readback, illegal/overrun/abort handling, WAIT bound and
// asynchronous reset.
module tb_fpu_cmd_sequencer;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_load;
  logic [7:0] tx_byte;
  logic       busy;

  int n_tests   = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int wait_n;

  fpu_cmd_sequencer_if #(.WIDTH(WIDTH)) fpu ();

  fpu_cmd_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .tx_load     (tx_load),
    .tx_byte     (tx_byte),
    .busy        (busy),
    .fpu         (fpu)
  );

  always #5 clk = ~clk;

  // Count issue pulses
  always @(posedge clk) begin
    if (fpu.fpu_start) start_cnt <= start_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic load();
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
  endtask

  task automatic fpu_finish(input int delay, input logic [31:0] res, input logic [3:0] flg);
    repeat (delay) tick();
    fpu.fpu_done   = 1'b1;
    fpu.fpu_result = res;
    fpu.fpu_flags  = flg;
    tick();
    fpu.fpu_done   = 1'b0;
    fpu.fpu_result = 32'h0;
    fpu.fpu_flags  = 4'h0;
  endtask

  initial begin
    rst_n          = 1'b0;
    frame_start    = 1'b0;
    rx_valid       = 1'b0;
    rx_byte        = 8'h00;
    tx_load        = 1'b0;
    fpu.fpu_done   = 1'b0;
    fpu.fpu_result = 32'h0;
    fpu.fpu_flags  = 4'h0;
    tick();
    tick();
    check_val("rst_tx", 64'(tx_byte), 64'h00);
    check_val("rst_busy", 64'(busy), 64'h0);
    check_val("rst_start", 64'(fpu.fpu_start), 64'h0);
    check_val("rst_a", 64'(fpu.fpu_a), 64'h0);
    rst_n = 1'b1;
    tick();

    // ADD 1.0 + 2.0
    frame();
    send_byte(8'h10);
    send_word(32'h3F800000);
    check_val("add_no_early_start", 64'(start_cnt), 64'd0);
    send_word(32'h40000000);
    check_val("add_start", 64'(fpu.fpu_start), 64'h1);
    check_val("add_op", 64'(fpu.fpu_op), 64'h1);
    check_val("add_a", 64'(fpu.fpu_a), 64'h3F800000);
    check_val("add_b", 64'(fpu.fpu_b), 64'h40000000);
    check_val("add_busy", 64'(busy), 64'h1);
    tick();
    check_val("add_start_pulse", 64'(fpu.fpu_start), 64'h0);
    check_val("add_wait_busy", 64'(busy), 64'h1);
    check_val("add_wait_status", 64'(tx_byte), 64'h80);
    fpu_finish(3, 32'h40400000, 4'h0);
    check_val("add_idle_busy", 64'(busy), 64'h0);
    check_val("add_one_start", 64'(start_cnt), 64'd1);
    check_val("add_status", 64'(tx_byte), 64'h00);
    frame();
    send_byte(8'h80);
    check_val("add_rd0", 64'(tx_byte), 64'h40);
    load();
    check_val("add_rd1", 64'(tx_byte), 64'h40);
    load();
    check_val("add_rd2", 64'(tx_byte), 64'h00);
    load();
    check_val("add_rd3", 64'(tx_byte), 64'h00);
    load();
    check_val("add_rd_end", 64'(tx_byte), 64'h00);

    // SQRT 4.0
    frame();
    send_byte(8'h50);
    send_word(32'h40800000);
    check_val("sqrt_start", 64'(fpu.fpu_start), 64'h1);
    check_val("sqrt_op", 64'(fpu.fpu_op), 64'h5);
    check_val("sqrt_a", 64'(fpu.fpu_a), 64'h40800000);
    check_val("sqrt_b_kept", 64'(fpu.fpu_b), 64'h40000000);
    tick();
    fpu_finish(2, 32'h40000000, 4'h0);
    frame();
    send_byte(8'h80);
    check_val("sqrt_rd0", 64'(tx_byte), 64'h40);
    load();
    check_val("sqrt_rd1", 64'(tx_byte), 64'h00);

    // Illegal command, then DIV with overrun and divzero
    frame();
    send_byte(8'hF0);
    check_val("ill_status", 64'(tx_byte), 64'h40);
    send_byte(8'h10);
    send_word(32'h3F800000);
    check_val("drop_no_start", 64'(start_cnt), 64'd2);
    check_val("drop_status", 64'(tx_byte), 64'h40);
    frame();
    send_byte(8'h40);
    send_word(32'h3F800000);
    send_word(32'h00000000);
    check_val("div_start", 64'(fpu.fpu_start), 64'h1);
    check_val("div_op", 64'(fpu.fpu_op), 64'h4);
    check_val("div_b", 64'(fpu.fpu_b), 64'h0);
    tick();
    send_byte(8'h00);
    check_val("poll_no_ovr", 64'(tx_byte), 64'hC0);
    send_byte(8'h55);
    check_val("ovr_status", 64'(tx_byte), 64'hE0);
    fpu_finish(1, 32'h7F800000, 4'b0100);
    check_val("div_status", 64'(tx_byte), 64'h64);
    frame();
    send_byte(8'h90);
    check_val("rdstat_before", 64'(tx_byte), 64'h64);
    load();
    check_val("rdstat_cleared", 64'(tx_byte), 64'h00);
    frame();
    send_byte(8'h80);
    check_val("div_rd0", 64'(tx_byte), 64'h7F);
    load();
    check_val("div_rd1", 64'(tx_byte), 64'h80);

    // Abort mid-operand, then MUL whose command rides on frame_start
    frame();
    send_byte(8'h30);
    send_byte(8'h3F);
    send_byte(8'h80);
    frame_start = 1'b1;
    rx_valid    = 1'b1;
    rx_byte     = 8'h30;
    tick();
    frame_start = 1'b0;
    rx_valid    = 1'b0;
    rx_byte     = 8'h00;
    check_val("abort_no_start", 64'(start_cnt), 64'd3);
    send_word(32'h40400000);
    send_word(32'h40000000);
    check_val("mul_start", 64'(fpu.fpu_start), 64'h1);
    check_val("mul_op", 64'(fpu.fpu_op), 64'h3);
    check_val("mul_a", 64'(fpu.fpu_a), 64'h40400000);
    check_val("mul_b", 64'(fpu.fpu_b), 64'h40000000);
    tick();
    frame();
    check_val("mul_frame_keeps_busy", 64'(busy), 64'h1);
    fpu_finish(1, 32'h40C00000, 4'h0);
    check_val("mul_idle", 64'(busy), 64'h0);
    frame();
    send_byte(8'h80);
    check_val("mul_rd0", 64'(tx_byte), 64'h40);
    load();
    check_val("mul_rd1", 64'(tx_byte), 64'hC0);

    // WAIT bound
    frame();
    send_byte(8'h50);
    send_word(32'h3F800000);
    check_val("wait_start", 64'(fpu.fpu_start), 64'h1);
    tick();
`ifdef FPU_SEQ_TIMEOUT_EN
    wait_n = 0;
    while (busy && wait_n < 400) begin
      tick();
      wait_n++;
    end
    check_val("tmo_cycles", 64'(wait_n), 64'(TIMEOUT));
    check_val("tmo_status", 64'(tx_byte), 64'h10);
    fpu_finish(0, 32'hDEADBEEF, 4'hF);
    check_val("late_done_status", 64'(tx_byte), 64'h10);
    check_val("late_done_busy", 64'(busy), 64'h0);
    frame();
    send_byte(8'h80);
    check_val("tmo_result_kept", 64'(tx_byte), 64'h40);
    load();
    check_val("tmo_result_kept1", 64'(tx_byte), 64'hC0);
    frame();
    send_byte(8'h90);
    load();
    check_val("tmo_cleared", 64'(tx_byte), 64'h00);
`else
    repeat (300) tick();
    check_val("nobound_busy", 64'(busy), 64'h1);
    check_val("nobound_status", 64'(tx_byte), 64'h80);
    fpu_finish(0, 32'h3F800000, 4'h0);
    check_val("nobound_done", 64'(busy), 64'h0);
    frame();
    send_byte(8'h80);
    check_val("nobound_rd0", 64'(tx_byte), 64'h3F);
`endif

    // Asynchronous reset during WAIT
    frame();
    send_byte(8'h10);
    send_word(32'h3F800000);
    send_word(32'h3F800000);
    tick();
    check_val("prerst_busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", 64'(busy), 64'h0);
    check_val("arst_start", 64'(fpu.fpu_start), 64'h0);
    check_val("arst_op", 64'(fpu.fpu_op), 64'h0);
    check_val("arst_a", 64'(fpu.fpu_a), 64'h0);
    check_val("arst_b", 64'(fpu.fpu_b), 64'h0);
    check_val("arst_tx", 64'(tx_byte), 64'h00);
    rst_n = 1'b1;
    tick();
    frame();
    send_byte(8'h80);
    check_val("arst_result", 64'(tx_byte), 64'h00);
    frame();
    send_byte(8'h10);
    send_word(32'h3F800000);
    send_word(32'h3F800000);
    check_val("post_start", 64'(fpu.fpu_start), 64'h1);
    check_val("post_a", 64'(fpu.fpu_a), 64'h3F800000);
    check_val("post_b", 64'(fpu.fpu_b), 64'h3F800000);
    tick();
    fpu_finish(2, 32'h40000000, 4'b0001);
    // Back-to-back: command on the first IDLE cycle
    send_byte(8'h50);
    send_word(32'h41100000);
    check_val("b2b_start", 64'(fpu.fpu_start), 64'h1);
    check_val("b2b_a", 64'(fpu.fpu_a), 64'h41100000);
    tick();
    fpu_finish(1, 32'h40400000, 4'b0000);
    check_val("b2b_status", 64'(tx_byte), 64'h01);
    frame();
    send_byte(8'h80);
    check_val("b2b_rd0", 64'(tx_byte), 64'h40);
    load();
    check_val("b2b_rd1", 64'(tx_byte), 64'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
